fft_seq_ctrl: RTL and testbench
===============================

# fft_seq_ctrl

Parametrised sequencer for an in-place radix-2 DIT FFT of N = 2^LOG2N complex points. It sits between the streaming sample interface and the buffer bank / butterfly datapath. It loads samples at bit-reversed addresses and issues every butterfly with its operand addresses and twiddle index. It enforces a pipeline drain between stages so no stage reads a location whose writeback is still in flight, then streams results out in natural order under ready/valid back-pressure.

## Interface
- LOG2N, 3: log2 of transform size; legal range 2..10.
- LAT, 7: butterfly datapath latency in cycles from issue to buffer writeback; legal range ≥ 1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- inverse  in  1  IFFT mode; captured on the accepted start.
- in_valid  in  1  input sample present.
- in_ready  out  1  sequencer accepts a sample this cycle.
- load_we  out  1  buffer write enable for the input sample (= in_valid & in_ready).
- load_addr  out  LOG2N  bit-reversed load address.
- bf_issue  out  1  butterfly issued this cycle.
- bf_a_addr, bf_b_addr  out  LOG2N each  butterfly operand addresses.
- tw_addr  out  LOG2N-1  twiddle ROM index.
- tw_conj  out  1  conjugate twiddle; equals the captured inverse.
- out_valid  out  1  result available at out_addr.
- out_ready  in  1  consumer accepts the result.
- out_addr  out  LOG2N  natural-order read address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, OUT.
- IDLE: start=1 → LOAD. Capture inverse and clear all counters.
- LOAD: in_ready=1. Each accepted sample writes to load_addr = bitrev(cnt), then cnt++. The accept of sample N-1 → ISSUE with stage s=0, k=0.
- ISSUE: bf_issue=1 every cycle, k = 0..N/2-1.
  - span = 2^s, grp = k>>s, pos = k & (span-1).
  - a = (grp<<(s+1)) | pos; b = a + span.
  - tw_addr = pos << (LOG2N-1-s).
  - After k = N/2-1 → DRAIN.
- DRAIN: wait exactly LAT cycles with bf_issue=0. Then, if s < LOG2N-1: s++, k=0 → ISSUE; otherwise → OUT with idx=0.
- OUT: out_valid=1 and out_addr=idx. The buffer read is combinational, so data is aligned with out_addr. idx advances only on out_valid & out_ready. Acceptance of idx N-1 → IDLE with done=1 in that same transition cycle.
- The block performs no scaling. For IFFT, the 1/N scaling belongs to downstream logic.
- start asserted outside IDLE is ignored. No queuing.
- in_valid outside LOAD is ignored. in_ready=0 there.
- An output stall (out_ready=0) holds out_addr and out_valid stable indefinitely.
- Counters wrap only through explicit state transitions. The index and k counters never overflow past N-1 and N/2-1.

## Timing
- Reset values: state=IDLE; in_ready, load_we, bf_issue, out_valid, busy, done = 0; all addresses = 0; tw_conj = 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). No done is produced.
- start → in_ready high on the next cycle.
- Gap-free load takes N cycles.
- Compute phase, from the first issue to the first out_valid: LOG2N·(N/2 + LAT) cycles.
- Output takes N cycles with out_ready held high.
- The last writeback of a stage lands in DRAIN cycle LAT. The first issue of the next stage is the cycle after that, so read-after-write is safe.
- done rises the cycle after the final out handshake, together with busy=0. A new start is accepted in that same cycle.
- All outputs are registered, except load_we, which is the AND of in_valid and in_ready.

## Test plan
- LOG2N=3, 8 consecutive samples → load_addr sequence 0,4,2,6,1,5,3,7; in_ready drops after the 8th sample.
- Compute phase with LOAD complete:
  - stage 0 issues (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0;
  - stage 1 issues (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2;
  - stage 2 issues (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3;
  - each stage is followed by exactly 7 idle cycles, 33 cycles total.
- OUT with out_ready toggling 1,0,0,1,… → out_addr holds during stalls, visits 0..7 once each, and done pulses once after address 7 is accepted.
- start pulsed during ISSUE, and in_valid driven during OUT → no effect on the sequence or counts; the frame completes normally.
- rst_n low during stage 1 of ISSUE → all outputs reset immediately. A fresh start afterwards gives a complete, correct frame.
- LOG2N=4, LAT=3 with inverse=1 → tw_conj=1 throughout; stage 3 tw_addr runs 0..7; compute takes 4·(8+3)=44 cycles.

Source files
------------

// File: rtl/fft_seq_ctrl_if.sv
// rtl/fft_seq_ctrl_if.sv - stream, buffer and butterfly signals of the FFT sequencer
// master drives start/samples/consumer-ready; slave is the sequencer itself.
interface fft_seq_ctrl_if #(
  parameter int LOG2N = 3
);
  logic             start;
  logic             inverse;
  logic             in_valid;
  logic             in_ready;
  logic             load_we;
  logic [LOG2N-1:0] load_addr;
  logic             bf_issue;
  logic [LOG2N-1:0] bf_a_addr;
  logic [LOG2N-1:0] bf_b_addr;
  logic [LOG2N-2:0] tw_addr;
  logic             tw_conj;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] out_addr;
  logic             busy;
  logic             done;

  modport master (
    output start, inverse, in_valid, out_ready,
    input  in_ready, load_we, load_addr, bf_issue, bf_a_addr, bf_b_addr,
           tw_addr, tw_conj, out_valid, out_addr, busy, done
  );

  modport slave (
    input  start, inverse, in_valid, out_ready,
    output in_ready, load_we, load_addr, bf_issue, bf_a_addr, bf_b_addr,
           tw_addr, tw_conj, out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - in-place radix-2 DIT FFT sequencer
// Loads bit-reversed, issues all butterflies stage by stage with a LAT-cycle drain, then streams out.
module fft_seq_ctrl #(
  parameter int LOG2N = 3,
  parameter int LAT   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_seq_ctrl_if.slave  io
);
  localparam int SW = $clog2(LOG2N);
  localparam int DW = $clog2(LAT + 1);
  localparam logic [SW-1:0] LAST_S    = SW'(LOG2N - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, OUT} state_t;

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-2:0] k;
  logic [SW-1:0]    s;
  logic [DW-1:0]    dcnt;
  logic             in_ready_q, bf_issue_q, out_valid_q, busy_q, done_q, tw_conj_q;
  logic [LOG2N-1:0] load_addr_q, a_q, b_q, out_addr_q;
  logic [LOG2N-2:0] tw_q;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [LOG2N-1:0] low_mask(input logic [SW-1:0] st);
    return (LOG2N'(1) << st) - LOG2N'(1);
  endfunction

  // Operand a is k with a zero bit inserted at position s; b sets that bit.
  function automatic logic [LOG2N-1:0] op_a(input logic [SW-1:0] st, input logic [LOG2N-2:0] kk);
    logic [LOG2N-1:0] kx;
    kx = {1'b0, kk};
    return ((kx & ~low_mask(st)) << 1) | (kx & low_mask(st));
  endfunction

  function automatic logic [LOG2N-1:0] op_b(input logic [SW-1:0] st, input logic [LOG2N-2:0] kk);
    return op_a(st, kk) | (LOG2N'(1) << st);
  endfunction

  function automatic logic [LOG2N-2:0] tw_idx(input logic [SW-1:0] st, input logic [LOG2N-2:0] kk);
    logic [LOG2N-1:0] t;
    t = ({1'b0, kk} & low_mask(st)) << (LAST_S - st);
    return t[LOG2N-2:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      k           <= '0;
      s           <= '0;
      dcnt        <= '0;
      in_ready_q  <= 1'b0;
      bf_issue_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tw_conj_q   <= 1'b0;
      load_addr_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tw_q        <= '0;
      out_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (io.start) begin
          state       <= LOAD;
          tw_conj_q   <= io.inverse;
          cnt         <= '0;
          k           <= '0;
          s           <= '0;
          dcnt        <= '0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b1;
          load_addr_q <= '0;
        end
        LOAD: if (io.in_valid) begin
          if (cnt == '1) begin
            state       <= ISSUE;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            load_addr_q <= '0;
            bf_issue_q  <= 1'b1;
            a_q         <= op_a('0, '0);
            b_q         <= op_b('0, '0);
            tw_q        <= tw_idx('0, '0);
          end else begin
            cnt         <= cnt + 1'b1;
            load_addr_q <= bitrev(cnt + 1'b1);
          end
        end
        ISSUE: if (k == '1) begin
          state      <= DRAIN;
          bf_issue_q <= 1'b0;
          dcnt       <= '0;
        end else begin
          k    <= k + 1'b1;
          a_q  <= op_a(s, k + 1'b1);
          b_q  <= op_b(s, k + 1'b1);
          tw_q <= tw_idx(s, k + 1'b1);
        end
        // The last writeback of the stage lands in the final drain cycle.
        DRAIN: if (dcnt == DRAIN_END) begin
          if (s == LAST_S) begin
            state       <= OUT;
            out_valid_q <= 1'b1;
            out_addr_q  <= '0;
            cnt         <= '0;
          end else begin
            state      <= ISSUE;
            s          <= s + 1'b1;
            k          <= '0;
            bf_issue_q <= 1'b1;
            a_q        <= op_a(s + 1'b1, '0);
            b_q        <= op_b(s + 1'b1, '0);
            tw_q       <= tw_idx(s + 1'b1, '0);
          end
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        OUT: if (io.out_ready) begin
          if (cnt == '1) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cnt        <= cnt + 1'b1;
            out_addr_q <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.load_we   = io.in_valid & in_ready_q;
  assign io.load_addr = load_addr_q;
  assign io.bf_issue  = bf_issue_q;
  assign io.bf_a_addr = a_q;
  assign io.bf_b_addr = b_q;
  assign io.tw_addr   = tw_q;
  assign io.tw_conj   = tw_conj_q;
  assign io.out_valid = out_valid_q;
  assign io.out_addr  = out_addr_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - bench for fft_seq_ctrl (N=8/LAT=7 and N=16/LAT=3 instances)
// A phase/cycle model of the frame is compared against both instances every negedge.
module tb_fft_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] st_r, inv_r, iv_r, or_r;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int m_st[2], m_cnt[2], m_t[2], m_inv[2], m_done[2];
  int first_iss[2], comp_len[2], done_cnt[2];
  int ld_log0[$], iss_log0[$], iss_log1[$], out_log0[$], out_log1[$];
  int exp_ld[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp_iss[12] = '{100, 20300, 40500, 60700, 200, 10302, 40600, 50702,
                      400, 10501, 20602, 30703};

  fft_seq_ctrl_if #(.LOG2N(3)) i0 ();
  fft_seq_ctrl_if #(.LOG2N(4)) i1 ();

  assign i0.start = st_r[0];  assign i0.inverse = inv_r[0];
  assign i0.in_valid = iv_r[0]; assign i0.out_ready = or_r[0];
  assign i1.start = st_r[1];  assign i1.inverse = inv_r[1];
  assign i1.in_valid = iv_r[1]; assign i1.out_ready = or_r[1];

  fft_seq_ctrl #(.LOG2N(3), .LAT(7)) u0 (.clk(clk), .rst_n(rst_n), .io(i0));
  fft_seq_ctrl #(.LOG2N(4), .LAT(3)) u1 (.clk(clk), .rst_n(rst_n), .io(i1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int brev(int x, int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // Frame model: idle(0) -> load(1) -> compute(2, cycle t) -> out(3).
  function automatic void model_step(int i, int lg, int lat, int rst, int stt, int inv,
                                     int iv, int ordy, int rdy, int we, int la, int bi,
                                     int a, int b, int tw, int tc, int ov, int oa,
                                     int bs, int dn);
    string p = (i == 0) ? "u0" : "u1";
    int n, h, per, s, k, span, ea, ei;
    n = 1 << lg; h = n / 2; per = h + lat;
    if (rst == 0) begin
      chk({p, ".rst_busy"}, bs, 0);      chk({p, ".rst_in_ready"}, rdy, 0);
      chk({p, ".rst_bf_issue"}, bi, 0);  chk({p, ".rst_out_valid"}, ov, 0);
      chk({p, ".rst_done"}, dn, 0);      chk({p, ".rst_tw_conj"}, tc, 0);
      chk({p, ".rst_addrs"}, la + a + b + tw + oa, 0);
      m_st[i] = 0; m_done[i] = 0; m_inv[i] = 0;
      first_iss[i] = -1; comp_len[i] = -1; done_cnt[i] = 0;
      return;
    end
    ei = int'(m_st[i] == 2 && (m_t[i] % per) < h);
    chk({p, ".in_ready"}, rdy, int'(m_st[i] == 1));
    chk({p, ".load_we"}, we, int'(m_st[i] == 1 && iv != 0));
    chk({p, ".busy"}, bs, int'(m_st[i] != 0));
    chk({p, ".done"}, dn, m_done[i]);
    chk({p, ".out_valid"}, ov, int'(m_st[i] == 3));
    chk({p, ".tw_conj"}, tc, m_inv[i]);
    chk({p, ".bf_issue"}, bi, ei);
    if (m_st[i] == 1) chk({p, ".load_addr"}, la, brev(m_cnt[i], lg));
    if (ei != 0) begin
      s = m_t[i] / per; k = m_t[i] % per; span = 1 << s;
      ea = (k >> s) * 2 * span + k % span;
      chk({p, ".bf_a_addr"}, a, ea);
      chk({p, ".bf_b_addr"}, b, ea + span);
      chk({p, ".tw_addr"}, tw, (k % span) << (lg - 1 - s));
    end
    if (m_st[i] == 3) chk({p, ".out_addr"}, oa, m_cnt[i]);
    if (we != 0 && i == 0) ld_log0.push_back(la);
    if (bi != 0) begin
      if (i == 0) iss_log0.push_back(a * 10000 + b * 100 + tw);
      else        iss_log1.push_back(a * 10000 + b * 100 + tw);
      if (first_iss[i] < 0) first_iss[i] = cyc;
    end
    if (ov != 0 && comp_len[i] < 0 && first_iss[i] >= 0) comp_len[i] = cyc - first_iss[i];
    if (ov != 0 && ordy != 0) begin
      if (i == 0) out_log0.push_back(oa); else out_log1.push_back(oa);
    end
    if (dn != 0) done_cnt[i]++;
    case (m_st[i])
      0: begin
        m_done[i] = 0;
        if (stt != 0) begin
          m_st[i] = 1; m_cnt[i] = 0; m_inv[i] = inv;
          first_iss[i] = -1; comp_len[i] = -1; done_cnt[i] = 0;
          if (i == 0) begin ld_log0.delete(); iss_log0.delete(); out_log0.delete(); end
          else begin iss_log1.delete(); out_log1.delete(); end
        end
      end
      1: if (iv != 0) begin
        m_cnt[i]++;
        if (m_cnt[i] == n) begin m_st[i] = 2; m_t[i] = 0; end
      end
      2: begin
        m_t[i]++;
        if (m_t[i] == lg * per) begin m_st[i] = 3; m_cnt[i] = 0; end
      end
      default: if (ordy != 0) begin
        if (m_cnt[i] == n - 1) begin m_st[i] = 0; m_done[i] = 1; end
        else m_cnt[i]++;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    model_step(0, 3, 7, int'(rst_n), int'(st_r[0]), int'(inv_r[0]), int'(iv_r[0]), int'(or_r[0]),
               int'(i0.in_ready), int'(i0.load_we), int'(i0.load_addr), int'(i0.bf_issue),
               int'(i0.bf_a_addr), int'(i0.bf_b_addr), int'(i0.tw_addr), int'(i0.tw_conj),
               int'(i0.out_valid), int'(i0.out_addr), int'(i0.busy), int'(i0.done));
    model_step(1, 4, 3, int'(rst_n), int'(st_r[1]), int'(inv_r[1]), int'(iv_r[1]), int'(or_r[1]),
               int'(i1.in_ready), int'(i1.load_we), int'(i1.load_addr), int'(i1.bf_issue),
               int'(i1.bf_a_addr), int'(i1.bf_b_addr), int'(i1.tw_addr), int'(i1.tw_conj),
               int'(i1.out_valid), int'(i1.out_addr), int'(i1.busy), int'(i1.done));
  end

  function automatic int sig_rdy(int inst);
    return (inst == 0) ? int'(i0.in_ready) : int'(i1.in_ready);
  endfunction
  function automatic int sig_ov(int inst);
    return (inst == 0) ? int'(i0.out_valid) : int'(i1.out_valid);
  endfunction
  function automatic int sig_done(int inst);
    return (inst == 0) ? int'(i0.done) : int'(i1.done);
  endfunction
  function automatic int sig_bi(int inst);
    return (inst == 0) ? int'(i0.bf_issue) : int'(i1.bf_issue);
  endfunction
  function automatic int sig_busy(int inst);
    return (inst == 0) ? int'(i0.busy) : int'(i1.busy);
  endfunction

  task automatic do_start(int inst, int inv);
    @(posedge clk); #1;
    st_r[inst] = 1'b1; inv_r[inst] = 1'(inv);
    @(posedge clk); #1;
    st_r[inst] = 1'b0;
    chk("in_ready_after_start", sig_rdy(inst), 1);
  endtask

  task automatic do_load(int inst, int gap);
    int sent = 0, g = 0, iv, rdy;
    int n = (inst == 0) ? 8 : 16;
    while (sent < n && g < 500) begin
      iv = (gap != 0) ? int'((g % 3) != 1) : 1;
      iv_r[inst] = 1'(iv);
      rdy = sig_rdy(inst);
      @(posedge clk); #1;
      if (iv != 0 && rdy != 0) sent++;
      g++;
    end
    iv_r[inst] = 1'b0;
    chk("load_count", sent, n);
    chk("in_ready_after_load", sig_rdy(inst), 0);
  endtask

  task automatic wait_out(int inst, int disturb);
    int g = 0, pulsed = 0;
    while (sig_ov(inst) == 0 && g < 1000) begin
      if (disturb != 0 && pulsed == 0 && sig_bi(inst) != 0) begin
        st_r[inst] = 1'b1; pulsed = 1;
      end else st_r[inst] = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    st_r[inst] = 1'b0;
    chk("reach_out", sig_ov(inst), 1);
    if (disturb != 0) chk("start_pulsed_in_issue", pulsed, 1);
  endtask

  task automatic do_out(int inst, int stall, int disturb);
    int j = 0;
    while (sig_done(inst) == 0 && j < 1000) begin
      or_r[inst] = (stall != 0) ? 1'((j % 3) == 0) : 1'b1;
      iv_r[inst] = 1'(disturb);
      @(posedge clk); #1;
      j++;
    end
    or_r[inst] = 1'b0; iv_r[inst] = 1'b0;
    chk("done_seen", sig_done(inst), 1);
    chk("busy_with_done", sig_busy(inst), 0);
  endtask

  task automatic run_frame(int inst, int inv, int gap, int stall, int disturb, int exp_comp);
    int n = (inst == 0) ? 8 : 16;
    do_start(inst, inv);
    do_load(inst, gap);
    wait_out(inst, disturb);
    do_out(inst, stall, disturb);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_pulse_count", done_cnt[inst], 1);
    chk("compute_cycles", comp_len[inst], exp_comp);
    chk("out_count", (inst == 0) ? out_log0.size() : out_log1.size(), n);
    for (int j = 0; j < n; j++)
      chk("out_order", (inst == 0) ? out_log0[j] : out_log1[j], j);
  endtask

  task automatic check_tables0();
    chk("load_log_size", ld_log0.size(), 8);
    for (int j = 0; j < 8; j++) chk("load_addr_seq", ld_log0[j], exp_ld[j]);
    chk("issue_log_size", iss_log0.size(), 12);
    for (int j = 0; j < 12; j++) chk("issue_seq", iss_log0[j], exp_iss[j]);
  endtask

  initial begin
    int g;
    rst_n = 1'b0; st_r = '0; inv_r = '0; iv_r = '0; or_r = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(i0.busy), 0);
    chk("reset_in_ready", int'(i0.in_ready), 0);
    chk("reset_out_valid", int'(i1.out_valid), 0);
    chk("reset_tw_conj", int'(i1.tw_conj), 0);
    chk("reset_load_addr", int'(i0.load_addr), 0);
    chk("reset_done", int'(i0.done), 0);
    rst_n = 1'b1;

    run_frame(0, 0, 0, 1, 0, 33);
    check_tables0();

    run_frame(0, 1, 1, 0, 1, 33);
    check_tables0();

    do_start(0, 0);
    do_load(0, 0);
    g = 0;
    while (!(iss_log0.size() >= 5 && sig_bi(0) != 0) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("reached_stage1", int'(iss_log0.size() >= 5), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_bf_issue", int'(i0.bf_issue), 0);
    chk("abort_busy", int'(i0.busy), 0);
    chk("abort_addrs", int'(i0.bf_a_addr) + int'(i0.bf_b_addr) + int'(i0.tw_addr), 0);
    chk("abort_done", int'(i0.done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(0, 0, 0, 1, 0, 33);
    check_tables0();

    run_frame(1, 1, 0, 0, 0, 44);
    chk("u1_issue_log_size", iss_log1.size(), 32);
    for (int j = 0; j < 8; j++) begin
      chk("u1_stage3_tw", iss_log1[24 + j] % 100, j);
      chk("u1_stage3_a", iss_log1[24 + j] / 10000, j);
    end
    chk("u1_tw_conj_held", int'(i1.tw_conj), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
